// File: rtl/fb_pkg.sv
// Shared framebuffer types and geometry for the write-side front end.
package fb_pkg;

  localparam int FB_W      = 320;
  localparam int FB_H      = 240;
  localparam int FB_PIXELS = FB_W * FB_H;
  localparam int FB_ADDR_W = 17;

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic [7:0] color;
  } pixel_t;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } wr_state_e;

endpackage

// File: rtl/vsync_edge_sync.sv
// Brings raw vsync into the clk domain and emits a 1-cycle pulse on its
// falling edge. The framebuffer uses the same block, so both swap decisions
// land on the same cycle.
module vsync_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_fall
);

  logic r_sync1, r_sync2, r_prev;

  // two-flop synchronizer plus one history flop for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_async;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_fall = r_prev & ~r_sync2;

endmodule

// File: rtl/fb_pixel_writer.sv
// Framebuffer write front end: turns the (x,y,colour) pixel stream into
// linear writes and clears the freshly released back buffer after each swap.
// Optional build macro FB_CLIP_EN: drop and count out-of-range pixels.
module fb_pixel_writer #(
  parameter int ADDR_WIDTH = fb_pkg::FB_ADDR_W,
  parameter int FB_W       = fb_pkg::FB_W,
  parameter int FB_H       = fb_pkg::FB_H
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vsync,
  input  logic                  clear_en,
  input  logic [7:0]            clear_color,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  input  logic [8:0]            pix_x,
  input  logic [7:0]            pix_y,
  input  logic [7:0]            pix_color,
  output logic                  busy,
  output logic                  wea,
  output logic [ADDR_WIDTH-1:0] addra,
  output logic [7:0]            dina,
  output logic [15:0]           drop_cnt
);
  import fb_pkg::*;

  localparam int                    PIXELS = FB_W * FB_H;
  localparam logic [ADDR_WIDTH-1:0] LAST   = ADDR_WIDTH'(PIXELS - 1);

  wr_state_e             r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic                  w_swap, w_accept, w_in_range;
  logic [ADDR_WIDTH-1:0] w_addr, w_x_ext, w_y_ext;
  pixel_t                w_pix;
  logic                  r_wea;
  logic [ADDR_WIDTH-1:0] r_addra;
  logic [7:0]            r_dina;

  vsync_edge_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (vsync),
    .o_fall  (w_swap)
  );

  assign w_pix   = {pix_x, pix_y, pix_color};
  assign w_x_ext = ADDR_WIDTH'(w_pix.x);
  assign w_y_ext = ADDR_WIDTH'(w_pix.y);

  // 320 = 256 + 64, so the row offset is two shifts and an add
  generate
    if (FB_W == 320) begin : g_addr_shift
      assign w_addr = (w_y_ext << 8) + (w_y_ext << 6) + w_x_ext;
    end else begin : g_addr_mul
      assign w_addr = (w_y_ext * ADDR_WIDTH'(FB_W)) + w_x_ext;
    end
  endgenerate

  // state and clear-address counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // a swap always restarts the clear, even on its final address
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      CLEAR: begin
        if (w_swap) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == LAST) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + ADDR_WIDTH'(1);
        end
      end
      RUN: begin
        if (w_swap && clear_en) begin
          w_state_nxt = CLEAR;
          w_cnt_nxt   = '0;
        end
      end
    endcase
  end

  // handshake outputs; ready drops in the swap cycle so no pixel straddles it
  always_comb begin
    busy      = (r_state == CLEAR);
    pix_ready = (r_state == RUN) && !w_swap;
  end

  assign w_accept = pix_valid & pix_ready;

`ifdef FB_CLIP_EN
  logic [15:0] r_drop;

  assign w_in_range = (int'(w_pix.x) < FB_W) && (int'(w_pix.y) < FB_H);

  // saturating count of clipped pixels
  always_ff @(posedge clk) begin
    if (rst)
      r_drop <= '0;
    else if (w_accept && !w_in_range && r_drop != 16'hFFFF)
      r_drop <= r_drop + 16'd1;
  end

  assign drop_cnt = r_drop;
`else
  assign w_in_range = 1'b1;
  assign drop_cnt   = '0;
`endif

  // registered write port: clear data while clearing, else accepted pixels
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wea   <= 1'b0;
      r_addra <= '0;
      r_dina  <= '0;
    end else if (r_state == CLEAR) begin
      r_wea   <= 1'b1;
      r_addra <= r_cnt;
      r_dina  <= clear_color;
    end else begin
      r_wea <= w_accept && w_in_range;
      if (w_accept) begin
        r_addra <= w_addr;
        r_dina  <= w_pix.color;
      end
    end
  end

  assign wea   = r_wea;
  assign addra = r_addra;
  assign dina  = r_dina;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Bench for fb_pixel_writer on a 320x4 frame so that every clear is short.
module tb_fb_pixel_writer;

  localparam int AW  = 17;
  localparam int W   = 320;
  localparam int H   = 4;
  localparam int PIX = W * H;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vsync = 1'b1;
  logic          clear_en = 1'b1;
  logic [7:0]    clear_color = 8'h25;
  logic          pix_valid = 1'b0;
  logic [8:0]    pix_x = '0;
  logic [7:0]    pix_y = '0;
  logic [7:0]    pix_color = '0;
  logic          pix_ready, busy, wea;
  logic [AW-1:0] addra;
  logic [7:0]    dina;
  logic [15:0]   drop_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int model_drop = 0;

  fb_pixel_writer #(.ADDR_WIDTH(AW), .FB_W(W), .FB_H(H)) dut (
    .clk(clk), .rst(rst), .vsync(vsync), .clear_en(clear_en),
    .clear_color(clear_color), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color), .busy(busy),
    .wea(wea), .addra(addra), .dina(dina), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // reference: linear address of (x,y), wrapped to the address width
  function automatic logic [AW-1:0] ref_addr(input int x, input int y);
    return AW'(y * W + x);
  endfunction

  // reference: does this pixel produce a framebuffer write
  function automatic bit ref_writes(input int x, input int y);
`ifdef FB_CLIP_EN
    return (x < W) && (y < H);
`else
    return 1'b1;
`endif
  endfunction

  task automatic drive_pix(input bit v, input int x, input int y, input logic [7:0] c);
    pix_valid = v;
    pix_x     = 9'(x);
    pix_y     = 8'(y);
    pix_color = c;
    if (v && !ref_writes(x, y)) model_drop++;
  endtask

  // walk a clear from the current negedge until busy drops; tallies writes
  task automatic collect_clear(input logic [7:0] color, output int nwr,
                               output int nbusy, output int nbad, output bit tmo);
    nwr = 0; nbusy = 0; nbad = 0; tmo = 1'b1;
    for (int i = 0; i < PIX + 50; i++) begin
      if (wea) begin
        if (addra !== AW'(nwr) || dina !== color) nbad++;
        nwr++;
      end
      if (busy) nbusy++;
      else begin
        tmo = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int nwr, nb, nbad;
    bit tmo;
    rst = 1'b1; clear_en = 1'b1; clear_color = 8'h25;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL reset_busy: got %b want 1", busy); end
    n_cmp++; if (pix_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", pix_ready); end
    n_cmp++; if (wea !== 1'b0 || addra !== '0 || dina !== '0) begin
      n_err++; $display("FAIL reset_port: got wea=%b addra=%0d dina=%0h want 0/0/0", wea, addra, dina); end
    n_cmp++; if (drop_cnt !== 16'd0) begin n_err++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
    rst = 1'b0;
    collect_clear(8'h25, nwr, nb, nbad, tmo);
    n_cmp++; if (tmo) begin n_err++; $display("FAIL reset_clear_timeout: busy still %b want 0", busy); end
    n_cmp++; if (nb != PIX) begin n_err++; $display("FAIL reset_busy_cycles: got %0d want %0d", nb, PIX); end
    n_cmp++; if (nwr != PIX || nbad != 0) begin
      n_err++; $display("FAIL reset_clear_writes: got %0d writes %0d bad want %0d/0", nwr, nbad, PIX); end
    n_cmp++; if (pix_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready_after: got %b want 1", pix_ready); end
  endtask

  task automatic test_corner();
    drive_pix(1'b1, W - 1, H - 1, 8'hE0);
    @(negedge clk);
    drive_pix(1'b0, 0, 0, 8'h00);
    n_cmp++; if (wea !== 1'b1 || addra !== AW'(PIX - 1) || dina !== 8'hE0) begin
      n_err++; $display("FAIL corner_pixel: got wea=%b addra=%0d dina=%0h want 1/%0d/e0", wea, addra, dina, PIX - 1); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    drive_pix(1'b1, 0, 0, 8'h11);
    @(negedge clk);
    drive_pix(1'b1, 1, 0, 8'h22);
    n_cmp++; if (wea !== 1'b1 || addra !== AW'(0) || dina !== 8'h11) begin
      n_err++; $display("FAIL b2b_first: got wea=%b addra=%0d dina=%0h want 1/0/11", wea, addra, dina); end
    @(negedge clk);
    drive_pix(1'b0, 0, 0, 8'h00);
    n_cmp++; if (wea !== 1'b1 || addra !== AW'(1) || dina !== 8'h22) begin
      n_err++; $display("FAIL b2b_second: got wea=%b addra=%0d dina=%0h want 1/1/22", wea, addra, dina); end
    @(negedge clk);
    n_cmp++; if (wea !== 1'b0) begin n_err++; $display("FAIL b2b_idle: got wea=%b want 0", wea); end
  endtask

  task automatic test_pixels();
    bit            exp_wea = 1'b0;
    logic [AW-1:0] exp_a = '0;
    logic [7:0]    exp_d = '0;
    for (int i = 0; i <= 300; i++) begin
      n_cmp++; if (wea !== exp_wea || (exp_wea && (addra !== exp_a || dina !== exp_d))) begin
        n_err++; $display("FAIL rand_write[%0d]: got wea=%b addra=%0d dina=%0h want %b/%0d/%0h",
                          i, wea, addra, dina, exp_wea, exp_a, exp_d); end
      n_cmp++; if (pix_ready !== 1'b1) begin n_err++; $display("FAIL rand_ready[%0d]: got %b want 1", i, pix_ready); end
      if (i < 300) begin
        bit v;
        int x, y;
        logic [7:0] c;
        v = ($urandom_range(0, 3) != 0);
        x = ($urandom_range(0, 9) == 0) ? int'($urandom_range(W, W + 10)) : int'($urandom_range(0, W - 1));
        y = ($urandom_range(0, 9) == 0) ? int'($urandom_range(H, H + 3)) : int'($urandom_range(0, H - 1));
        c = 8'($urandom);
        drive_pix(v, x, y, c);
        exp_wea = v && ref_writes(x, y);
        exp_a   = ref_addr(x, y);
        exp_d   = c;
      end else begin
        drive_pix(1'b0, 0, 0, 8'h00);
      end
      @(negedge clk);
    end
    n_cmp++; if (drop_cnt !== 16'(model_drop)) begin
      n_err++; $display("FAIL rand_drop_cnt: got %0d want %0d", drop_cnt, model_drop); end
  endtask

  task automatic test_clip();
    drive_pix(1'b1, W, 5, 8'h5A);
    @(negedge clk);
    drive_pix(1'b1, 5, H, 8'hA5);
    n_cmp++; if (wea !== ref_writes(W, 5) || (wea && addra !== ref_addr(W, 5))) begin
      n_err++; $display("FAIL clip_x: got wea=%b addra=%0d want %b/%0d", wea, addra, ref_writes(W, 5), ref_addr(W, 5)); end
    n_cmp++; if (drop_cnt !== 16'(model_drop - (ref_writes(5, H) ? 0 : 1))) begin
      n_err++; $display("FAIL clip_x_drop: got %0d want %0d", drop_cnt, model_drop - (ref_writes(5, H) ? 0 : 1)); end
    @(negedge clk);
    drive_pix(1'b0, 0, 0, 8'h00);
    n_cmp++; if (wea !== ref_writes(5, H) || (wea && addra !== ref_addr(5, H))) begin
      n_err++; $display("FAIL clip_y: got wea=%b addra=%0d want %b/%0d", wea, addra, ref_writes(5, H), ref_addr(5, H)); end
    n_cmp++; if (drop_cnt !== 16'(model_drop)) begin
      n_err++; $display("FAIL clip_y_drop: got %0d want %0d", drop_cnt, model_drop); end
    @(negedge clk);
  endtask

  task automatic test_swap_noclear();
    clear_en = 1'b0;
    drive_pix(1'b1, 10, 1, 8'h3C);
    vsync = 1'b0;
    @(negedge clk);
    n_cmp++; if (pix_ready !== 1'b1) begin n_err++; $display("FAIL noclr_ready_pre: got %b want 1", pix_ready); end
    @(negedge clk);
    n_cmp++; if (pix_ready !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL noclr_swap_cycle: got ready=%b busy=%b want 0/0", pix_ready, busy); end
    n_cmp++; if (wea !== 1'b1 || addra !== ref_addr(10, 1)) begin
      n_err++; $display("FAIL noclr_write_pre: got wea=%b addra=%0d want 1/%0d", wea, addra, ref_addr(10, 1)); end
    @(negedge clk);
    n_cmp++; if (pix_ready !== 1'b1 || busy !== 1'b0 || wea !== 1'b0) begin
      n_err++; $display("FAIL noclr_after: got ready=%b busy=%b wea=%b want 1/0/0", pix_ready, busy, wea); end
    vsync = 1'b1;
    @(negedge clk);
    drive_pix(1'b0, 0, 0, 8'h00);
    n_cmp++; if (wea !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL noclr_resume: got wea=%b busy=%b want 1/0", wea, busy); end
    @(negedge clk);
  endtask

  task automatic test_swap_clear();
    int nwr, nb, nbad;
    bit tmo;
    logic [7:0] col;
    col = 8'($urandom);
    clear_en = 1'b1; clear_color = col;
    drive_pix(1'b1, 7, 2, 8'h77);
    vsync = 1'b0;
    @(negedge clk);
    n_cmp++; if (pix_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL swclr_pre: got ready=%b busy=%b want 1/0", pix_ready, busy); end
    @(negedge clk);
    n_cmp++; if (pix_ready !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL swclr_swap_cycle: got ready=%b busy=%b want 0/0", pix_ready, busy); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1 || pix_ready !== 1'b0 || wea !== 1'b0) begin
      n_err++; $display("FAIL swclr_enter: got busy=%b ready=%b wea=%b want 1/0/0", busy, pix_ready, wea); end
    vsync = 1'b1;
    collect_clear(col, nwr, nb, nbad, tmo);
    n_cmp++; if (tmo || nb != PIX || nwr != PIX || nbad != 0) begin
      n_err++; $display("FAIL swclr_clear: got tmo=%b busy=%0d writes=%0d bad=%0d want 0/%0d/%0d/0", tmo, nb, nwr, nbad, PIX, PIX); end
    n_cmp++; if (pix_ready !== 1'b1) begin n_err++; $display("FAIL swclr_ready_after: got %b want 1", pix_ready); end
    @(negedge clk);
    drive_pix(1'b0, 0, 0, 8'h00);
    n_cmp++; if (wea !== 1'b1 || addra !== ref_addr(7, 2) || dina !== 8'h77) begin
      n_err++; $display("FAIL swclr_held_pixel: got wea=%b addra=%0d dina=%0h want 1/%0d/77", wea, addra, dina, ref_addr(7, 2)); end
    @(negedge clk);
  endtask

  // start a swap-triggered clear; returns on the first CLEAR negedge
  task automatic start_clear();
    clear_en = 1'b1;
    vsync = 1'b0;
    repeat (3) @(negedge clk);
    vsync = 1'b1;
  endtask

  task automatic test_swap_during_clear();
    int nwr, nb, nbad;
    bit tmo;
    clear_color = 8'h81;
    start_clear();
    repeat (1000) @(negedge clk);
    n_cmp++; if (wea !== 1'b1 || addra !== AW'(999)) begin
      n_err++; $display("FAIL midclr_progress: got wea=%b addra=%0d want 1/999", wea, addra); end
    vsync = 1'b0;
    repeat (3) @(negedge clk);
    vsync = 1'b1;
    n_cmp++; if (busy !== 1'b1 || addra !== AW'(1002)) begin
      n_err++; $display("FAIL midclr_swap: got busy=%b addra=%0d want 1/1002", busy, addra); end
    @(negedge clk);
    collect_clear(8'h81, nwr, nb, nbad, tmo);
    n_cmp++; if (tmo || nwr != PIX || nbad != 0 || nb != PIX - 1) begin
      n_err++; $display("FAIL midclr_restart: got tmo=%b writes=%0d bad=%0d busy=%0d want 0/%0d/0/%0d", tmo, nwr, nbad, nb, PIX, PIX - 1); end
    @(negedge clk);
  endtask

  task automatic test_swap_last();
    int nwr, nb, nbad;
    bit tmo;
    clear_color = 8'h3E;
    start_clear();
    repeat (PIX - 3) @(negedge clk);
    n_cmp++; if (addra !== AW'(PIX - 4)) begin
      n_err++; $display("FAIL last_align: got addra=%0d want %0d", addra, PIX - 4); end
    vsync = 1'b0;
    repeat (3) @(negedge clk);
    vsync = 1'b1;
    n_cmp++; if (busy !== 1'b1 || addra !== AW'(PIX - 1)) begin
      n_err++; $display("FAIL last_swap_wins: got busy=%b addra=%0d want 1/%0d", busy, addra, PIX - 1); end
    @(negedge clk);
    collect_clear(8'h3E, nwr, nb, nbad, tmo);
    n_cmp++; if (tmo || nwr != PIX || nbad != 0 || nb != PIX - 1) begin
      n_err++; $display("FAIL last_restart: got tmo=%b writes=%0d bad=%0d busy=%0d want 0/%0d/0/%0d", tmo, nwr, nbad, nb, PIX, PIX - 1); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_clear();
    int nwr, nb, nbad;
    bit tmo, found;
    clear_color = 8'hC3;
    start_clear();
    found = 1'b0;
    for (int i = 0; i < PIX; i++) begin
      @(negedge clk);
      if (wea && addra == AW'(499)) begin
        found = 1'b1;
        break;
      end
    end
    n_cmp++; if (!found) begin n_err++; $display("FAIL rstmid_reach: got no write at 499 want one"); end
    rst = 1'b1;
    @(negedge clk);
    model_drop = 0;
    n_cmp++; if (wea !== 1'b0 || busy !== 1'b1 || pix_ready !== 1'b0 || drop_cnt !== 16'd0) begin
      n_err++; $display("FAIL rstmid_state: got wea=%b busy=%b ready=%b drop=%0d want 0/1/0/0", wea, busy, pix_ready, drop_cnt); end
    rst = 1'b0;
    collect_clear(8'hC3, nwr, nb, nbad, tmo);
    n_cmp++; if (tmo || nwr != PIX || nbad != 0 || nb != PIX) begin
      n_err++; $display("FAIL rstmid_restart: got tmo=%b writes=%0d bad=%0d busy=%0d want 0/%0d/0/%0d", tmo, nwr, nbad, nb, PIX, PIX); end
  endtask

  initial begin
    test_reset();
    test_corner();
    test_back_to_back();
    test_pixels();
    test_clip();
    test_swap_noclear();
    test_swap_clear();
    test_swap_during_clear();
    test_swap_last();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
